// File: rtl/snes_mem_sequencer_if.sv
// Bus bundle between the SNES decoder / GSU core / memory controller side
// (master) and the memory sequencer (slave).
interface snes_mem_sequencer_if #(
  parameter int ADDR_W = 24
);
  logic              snes_rd_start;
  logic              snes_wr_end;
  logic [7:0]        snes_data_in;
  logic [ADDR_W-1:0] rom_addr;
  logic              rom_hit;
  logic              is_writable;
  logic [7:0]        snes_rdata;
  logic              snes_rdata_valid;
  logic              gsu_req;
  logic              gsu_we;
  logic [ADDR_W-1:0] gsu_addr;
  logic [7:0]        gsu_wdata;
  logic              gsu_ack;
  logic [7:0]        gsu_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic              busy;

  modport master (
    output snes_rd_start, snes_wr_end, snes_data_in, rom_addr, rom_hit, is_writable,
    input  snes_rdata, snes_rdata_valid,
    output gsu_req, gsu_we, gsu_addr, gsu_wdata,
    input  gsu_ack, gsu_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  busy
  );

  modport slave (
    input  snes_rd_start, snes_wr_end, snes_data_in, rom_addr, rom_hit, is_writable,
    output snes_rdata, snes_rdata_valid,
    input  gsu_req, gsu_we, gsu_addr, gsu_wdata,
    output gsu_ack, gsu_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output busy
  );
endinterface

// File: rtl/snes_mem_sequencer.sv
// Sequences SNES SRAM0 reads/writes onto the single memory-controller port and
// arbitrates it against GSU requests, SNES first, with a post-SNES GSU holdoff.
module snes_mem_sequencer #(
  parameter int ADDR_W      = 24,
  parameter int GSU_HOLDOFF = 2
) (
  input logic                 clk_i,
  input logic                 rst_i,
  snes_mem_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNES_WR,
    ST_SNES_RD,
    ST_GSU_ACC
  } state_e;

  localparam int             HW        = (GSU_HOLDOFF < 2) ? 1 : $clog2(GSU_HOLDOFF + 1);
  localparam logic [HW-1:0]  HOLD_LOAD = HW'(GSU_HOLDOFF);

  state_e            state_q, state_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_pend_q, wr_pend_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [HW-1:0]     holdoff_q, holdoff_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        snes_rdata_q, snes_rdata_d;
  logic              snes_rdata_valid_q, snes_rdata_valid_d;
  logic              gsu_ack_q, gsu_ack_d;
  logic [7:0]        gsu_rdata_q, gsu_rdata_d;

  logic rd_cap;
  logic wr_cap;

  assign rd_cap = bus.snes_rd_start & bus.rom_hit;
  assign wr_cap = bus.snes_wr_end & bus.rom_hit & bus.is_writable;

  always_comb begin
    state_d            = state_q;
    rd_pend_d          = rd_pend_q;
    rd_addr_d          = rd_addr_q;
    wr_pend_d          = wr_pend_q;
    wr_addr_d          = wr_addr_q;
    wr_data_d          = wr_data_q;
    holdoff_d          = (holdoff_q != '0) ? holdoff_q - HW'(1) : '0;
    mem_req_d          = mem_req_q;
    mem_we_d           = mem_we_q;
    mem_addr_d         = mem_addr_q;
    mem_wdata_d        = mem_wdata_q;
    snes_rdata_d       = snes_rdata_q;
    snes_rdata_valid_d = 1'b0;
    gsu_ack_d          = 1'b0;
    gsu_rdata_d        = gsu_rdata_q;

    // Pending slots hold only the newest unissued request of each type.
    if (rd_cap) begin
      rd_pend_d = 1'b1;
      rd_addr_d = bus.rom_addr;
    end
    if (wr_cap) begin
      wr_pend_d = 1'b1;
      wr_addr_d = bus.rom_addr;
      wr_data_d = bus.snes_data_in;
    end

    case (state_q)
      ST_IDLE: begin
        // The flag is cleared at issue so a capture during flight queues a new access.
        if (wr_pend_d) begin
          state_d     = ST_SNES_WR;
          wr_pend_d   = 1'b0;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_addr_d;
          mem_wdata_d = wr_data_d;
        end else if (rd_pend_d) begin
          state_d    = ST_SNES_RD;
          rd_pend_d  = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = rd_addr_d;
        end else if (bus.gsu_req && (holdoff_q == '0)) begin
          state_d     = ST_GSU_ACC;
          mem_req_d   = 1'b1;
          mem_we_d    = bus.gsu_we;
          mem_addr_d  = bus.gsu_addr;
          mem_wdata_d = bus.gsu_wdata;
        end
      end
      ST_SNES_WR: begin
        if (bus.mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          holdoff_d = HOLD_LOAD;
        end
      end
      ST_SNES_RD: begin
        if (bus.mem_ack) begin
          state_d            = ST_IDLE;
          mem_req_d          = 1'b0;
          snes_rdata_d       = bus.mem_rdata;
          snes_rdata_valid_d = 1'b1;
          holdoff_d          = HOLD_LOAD;
        end
      end
      ST_GSU_ACC: begin
        if (bus.mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          gsu_ack_d = 1'b1;
          if (!mem_we_q) begin
            gsu_rdata_d = bus.mem_rdata;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q            <= ST_IDLE;
      rd_pend_q          <= 1'b0;
      rd_addr_q          <= '0;
      wr_pend_q          <= 1'b0;
      wr_addr_q          <= '0;
      wr_data_q          <= '0;
      holdoff_q          <= '0;
      mem_req_q          <= 1'b0;
      mem_we_q           <= 1'b0;
      mem_addr_q         <= '0;
      mem_wdata_q        <= '0;
      snes_rdata_q       <= '0;
      snes_rdata_valid_q <= 1'b0;
      gsu_ack_q          <= 1'b0;
      gsu_rdata_q        <= '0;
    end else begin
      state_q            <= state_d;
      rd_pend_q          <= rd_pend_d;
      rd_addr_q          <= rd_addr_d;
      wr_pend_q          <= wr_pend_d;
      wr_addr_q          <= wr_addr_d;
      wr_data_q          <= wr_data_d;
      holdoff_q          <= holdoff_d;
      mem_req_q          <= mem_req_d;
      mem_we_q           <= mem_we_d;
      mem_addr_q         <= mem_addr_d;
      mem_wdata_q        <= mem_wdata_d;
      snes_rdata_q       <= snes_rdata_d;
      snes_rdata_valid_q <= snes_rdata_valid_d;
      gsu_ack_q          <= gsu_ack_d;
      gsu_rdata_q        <= gsu_rdata_d;
    end
  end

  assign bus.mem_req          = mem_req_q;
  assign bus.mem_we           = mem_we_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_wdata        = mem_wdata_q;
  assign bus.snes_rdata       = snes_rdata_q;
  assign bus.snes_rdata_valid = snes_rdata_valid_q;
  assign bus.gsu_ack          = gsu_ack_q;
  assign bus.gsu_rdata        = gsu_rdata_q;
  assign bus.busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_snes_mem_sequencer.sv
// Directed bench for snes_mem_sequencer: read, write, arbitration/holdoff,
// pending overwrite, reset mid-access and write-before-read ordering.
module tb_snes_mem_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  snes_mem_sequencer_if #(.ADDR_W(24)) bus ();

  snes_mem_sequencer #(.ADDR_W(24), .GSU_HOLDOFF(2)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.snes_rd_start = 1'b0;
    bus.snes_wr_end   = 1'b0;
    bus.snes_data_in  = 8'h00;
    bus.rom_addr      = 24'h0;
    bus.rom_hit       = 1'b0;
    bus.is_writable   = 1'b0;
    bus.gsu_req       = 1'b0;
    bus.gsu_we        = 1'b0;
    bus.gsu_addr      = 24'h0;
    bus.gsu_wdata     = 8'h00;
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    tests_run++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.snes_rdata,
         bus.snes_rdata_valid, bus.gsu_ack, bus.gsu_rdata, bus.busy} !== '0) begin
      $display("FAIL reset_outputs: req=%0b we=%0b addr=%h wd=%h srd=%h v=%0b ack=%0b grd=%h busy=%0b, want all 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.snes_rdata,
               bus.snes_rdata_valid, bus.gsu_ack, bus.gsu_rdata, bus.busy);
      tests_failed++;
    end
    $display("[TB] reset done");
  endtask

  task automatic test_snes_read();
    bus.rom_hit = 1'b1; bus.rom_addr = 24'h012345; bus.snes_rd_start = 1'b1;
    tick();
    bus.snes_rd_start = 1'b0;
    tests_run++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.busy} !== {1'b1, 1'b0, 24'h012345, 1'b1}) begin
      $display("FAIL rd_issue: req=%0b we=%0b addr=%h busy=%0b, want 1 0 012345 1",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.busy);
      tests_failed++;
    end
    tick(); tick();
    tests_run++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 24'h012345) begin
      $display("FAIL rd_hold: req=%0b addr=%h, want 1 012345", bus.mem_req, bus.mem_addr);
      tests_failed++;
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hA5;
    tick();
    bus.mem_ack = 1'b0; bus.mem_rdata = 8'h00;
    tests_run++;
    if ({bus.mem_req, bus.snes_rdata_valid, bus.snes_rdata, bus.busy} !== {1'b0, 1'b1, 8'hA5, 1'b0}) begin
      $display("FAIL rd_done: req=%0b valid=%0b rdata=%h busy=%0b, want 0 1 a5 0",
               bus.mem_req, bus.snes_rdata_valid, bus.snes_rdata, bus.busy);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (bus.snes_rdata_valid !== 1'b0 || bus.snes_rdata !== 8'hA5) begin
      $display("FAIL rd_pulse_once: valid=%0b rdata=%h, want 0 a5", bus.snes_rdata_valid, bus.snes_rdata);
      tests_failed++;
    end
    $display("[TB] snes read 012345 -> %h", bus.snes_rdata);
  endtask

  task automatic test_snes_write();
    bus.rom_hit = 1'b1; bus.rom_addr = 24'hE00010; bus.is_writable = 1'b1;
    bus.snes_data_in = 8'h3C; bus.snes_wr_end = 1'b1;
    tick();
    bus.snes_wr_end = 1'b0;
    tests_run++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 24'hE00010, 8'h3C}) begin
      $display("FAIL wr_issue: req=%0b we=%0b addr=%h wd=%h, want 1 1 e00010 3c",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      tests_failed++;
    end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tests_run++;
    if ({bus.mem_req, bus.snes_rdata_valid, bus.busy} !== 3'b000) begin
      $display("FAIL wr_done: req=%0b valid=%0b busy=%0b, want 0 0 0",
               bus.mem_req, bus.snes_rdata_valid, bus.busy);
      tests_failed++;
    end
    $display("[TB] snes write e00010 <- 3c");
    bus.is_writable = 1'b0; bus.snes_data_in = 8'h55; bus.snes_wr_end = 1'b1;
    tick();
    bus.snes_wr_end = 1'b0;
    tick();
    tests_run++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL wr_not_writable: req=%0b busy=%0b, want 0 0", bus.mem_req, bus.busy);
      tests_failed++;
    end
    bus.rom_hit = 1'b0; bus.snes_rd_start = 1'b1;
    tick();
    bus.snes_rd_start = 1'b0;
    tests_run++;
    if (bus.mem_req !== 1'b0) begin
      $display("FAIL rd_no_hit: req=%0b, want 0", bus.mem_req);
      tests_failed++;
    end
    $display("[TB] non-writable write and non-hit read dropped");
    tick(); tick(); tick();
  endtask

  task automatic test_arbitration();
    bus.gsu_req = 1'b1; bus.gsu_we = 1'b0; bus.gsu_addr = 24'h000100;
    bus.rom_hit = 1'b1; bus.rom_addr = 24'h000200; bus.snes_rd_start = 1'b1;
    tick();
    bus.snes_rd_start = 1'b0;
    tests_run++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 24'h000200}) begin
      $display("FAIL arb_snes_first: req=%0b we=%0b addr=%h, want 1 0 000200",
               bus.mem_req, bus.mem_we, bus.mem_addr);
      tests_failed++;
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h11;
    tick();
    bus.mem_ack = 1'b0;
    tests_run++;
    if (bus.snes_rdata_valid !== 1'b1 || bus.snes_rdata !== 8'h11 || bus.mem_req !== 1'b0) begin
      $display("FAIL arb_snes_done: valid=%0b rdata=%h req=%0b, want 1 11 0",
               bus.snes_rdata_valid, bus.snes_rdata, bus.mem_req);
      tests_failed++;
    end
    // Holdoff 2 loaded at completion: counts 2,1 in IDLE, grant when it reads 0.
    tick();
    tests_run++;
    if (bus.mem_req !== 1'b0) begin
      $display("FAIL arb_holdoff1: req=%0b, want 0", bus.mem_req);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (bus.mem_req !== 1'b0) begin
      $display("FAIL arb_holdoff2: req=%0b, want 0", bus.mem_req);
      tests_failed++;
    end
    tick();
    tests_run++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 24'h000100}) begin
      $display("FAIL arb_gsu_grant: req=%0b we=%0b addr=%h, want 1 0 000100",
               bus.mem_req, bus.mem_we, bus.mem_addr);
      tests_failed++;
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h5A;
    tick();
    bus.mem_ack = 1'b0; bus.gsu_req = 1'b0;
    tests_run++;
    if ({bus.gsu_ack, bus.gsu_rdata, bus.mem_req} !== {1'b1, 8'h5A, 1'b0}) begin
      $display("FAIL arb_gsu_done: ack=%0b rdata=%h req=%0b, want 1 5a 0",
               bus.gsu_ack, bus.gsu_rdata, bus.mem_req);
      tests_failed++;
    end
    tick();
    tests_run++;
    if (bus.gsu_ack !== 1'b0 || bus.mem_req !== 1'b0) begin
      $display("FAIL arb_gsu_ack_once: ack=%0b req=%0b, want 0 0", bus.gsu_ack, bus.mem_req);
      tests_failed++;
    end
    $display("[TB] arbitration snes 000200 then gsu 000100 -> %h", bus.gsu_rdata);
  endtask

  task automatic test_overwrite();
    int req_cycles;
    bus.gsu_req = 1'b1; bus.gsu_we = 1'b1; bus.gsu_addr = 24'h000300; bus.gsu_wdata = 8'hC3;
    tick();
    tests_run++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 24'h000300, 8'hC3}) begin
      $display("FAIL ovw_gsu_issue: req=%0b we=%0b addr=%h wd=%h, want 1 1 000300 c3",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      tests_failed++;
    end
    bus.rom_hit = 1'b1; bus.rom_addr = 24'h000010; bus.snes_rd_start = 1'b1;
    tick();
    bus.rom_addr = 24'h000020;
    tick();
    bus.snes_rd_start = 1'b0;
    tests_run++;
    if (bus.mem_addr !== 24'h000300 || bus.mem_we !== 1'b1) begin
      $display("FAIL ovw_no_preempt: addr=%h we=%0b, want 000300 1", bus.mem_addr, bus.mem_we);
      tests_failed++;
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h77;
    tick();
    bus.mem_ack = 1'b0; bus.gsu_req = 1'b0;
    tests_run++;
    if (bus.gsu_ack !== 1'b1 || bus.gsu_rdata !== 8'h5A) begin
      $display("FAIL ovw_gsu_write_done: ack=%0b rdata=%h, want 1 5a", bus.gsu_ack, bus.gsu_rdata);
      tests_failed++;
    end
    tick();
    tests_run++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 24'h000020}) begin
      $display("FAIL ovw_rd_issue: req=%0b we=%0b addr=%h, want 1 0 000020",
               bus.mem_req, bus.mem_we, bus.mem_addr);
      tests_failed++;
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h99;
    tick();
    bus.mem_ack = 1'b0;
    tests_run++;
    if (bus.snes_rdata_valid !== 1'b1 || bus.snes_rdata !== 8'h99) begin
      $display("FAIL ovw_rd_done: valid=%0b rdata=%h, want 1 99", bus.snes_rdata_valid, bus.snes_rdata);
      tests_failed++;
    end
    req_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.mem_req === 1'b1) req_cycles++;
    end
    tests_run++;
    if (req_cycles != 0) begin
      $display("FAIL ovw_single_access: extra req cycles=%0d, want 0", req_cycles);
      tests_failed++;
    end
    $display("[TB] overwrite: one read at 000020 -> %h", bus.snes_rdata);
  endtask

  task automatic test_reset_mid();
    bus.rom_hit = 1'b1; bus.rom_addr = 24'h000400; bus.snes_rd_start = 1'b1;
    tick();
    bus.snes_rd_start = 1'b0;
    tests_run++;
    if (bus.mem_req !== 1'b1) begin
      $display("FAIL rst_mid_issue: req=%0b, want 1", bus.mem_req);
      tests_failed++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests_run++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.snes_rdata,
         bus.snes_rdata_valid, bus.gsu_ack, bus.gsu_rdata, bus.busy} !== '0) begin
      $display("FAIL rst_mid_outputs: req=%0b addr=%h srd=%h grd=%h busy=%0b, want all 0",
               bus.mem_req, bus.mem_addr, bus.snes_rdata, bus.gsu_rdata, bus.busy);
      tests_failed++;
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'hEE;
    tick();
    bus.mem_ack = 1'b0;
    tests_run++;
    if ({bus.snes_rdata_valid, bus.gsu_ack, bus.mem_req, bus.snes_rdata} !== {3'b000, 8'h00}) begin
      $display("FAIL rst_late_ack: valid=%0b ack=%0b req=%0b rdata=%h, want 0 0 0 00",
               bus.snes_rdata_valid, bus.gsu_ack, bus.mem_req, bus.snes_rdata);
      tests_failed++;
    end
    $display("[TB] reset mid-access, late ack ignored");
    tick();
  endtask

  task automatic test_back_to_back();
    bus.rom_hit = 1'b1; bus.is_writable = 1'b1; bus.rom_addr = 24'h000500;
    bus.snes_data_in = 8'h42; bus.snes_wr_end = 1'b1; bus.snes_rd_start = 1'b1;
    tick();
    bus.snes_wr_end = 1'b0; bus.snes_rd_start = 1'b0;
    tests_run++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 24'h000500, 8'h42}) begin
      $display("FAIL b2b_write_first: req=%0b we=%0b addr=%h wd=%h, want 1 1 000500 42",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
      tests_failed++;
    end
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tests_run++;
    if (bus.mem_req !== 1'b0) begin
      $display("FAIL b2b_write_done: req=%0b, want 0", bus.mem_req);
      tests_failed++;
    end
    tick();
    tests_run++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b0, 24'h000500}) begin
      $display("FAIL b2b_read_second: req=%0b we=%0b addr=%h, want 1 0 000500",
               bus.mem_req, bus.mem_we, bus.mem_addr);
      tests_failed++;
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = 8'h33;
    tick();
    bus.mem_ack = 1'b0;
    tests_run++;
    if ({bus.snes_rdata_valid, bus.snes_rdata, bus.mem_req} !== {1'b1, 8'h33, 1'b0}) begin
      $display("FAIL b2b_read_done: valid=%0b rdata=%h req=%0b, want 1 33 0",
               bus.snes_rdata_valid, bus.snes_rdata, bus.mem_req);
      tests_failed++;
    end
    $display("[TB] back-to-back write 000500 then read -> %h", bus.snes_rdata);
  endtask

  initial begin
    test_reset();
    test_snes_read();
    test_snes_write();
    test_arbitration();
    test_overwrite();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
